// File: rtl/alu_cmd_sequencer.sv
// Command sequencer wrapping a 4-bit combinational ALU as an accumulator machine.
// Commands arrive over valid/ready; each produces one response carrying the accumulator.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// EXEC  | ALU inputs driven from captured command, accumulator updated at end of cycle
// RESP  | response held on rsp_* until rsp_ready

module alu_cmd_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [3:0]       cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [2:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [3:0]       alu_result,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       acc;
    logic [3:0]       acc_nxt;
    logic [3:0]       op_q;
    logic [3:0]       imm_q;
    logic             err_q;
    logic             err_nxt;
    logic             zero_q;
    logic [CNT_W-1:0] op_count_q;
    logic             cmd_fire;
    logic             rsp_fire;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Command decode: only the ALU ops take alu_result; illegal codes keep acc.
    always_comb begin
        acc_nxt = acc;
        err_nxt = 1'b0;
        case (op_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: acc_nxt = alu_result;
            4'b1000: acc_nxt = imm_q;
            4'b1001: acc_nxt = 4'h0;
            4'b1010: acc_nxt = acc;
            default: err_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= 4'h0;
            op_q       <= 4'h0;
            imm_q      <= 4'h0;
            err_q      <= 1'b0;
            zero_q     <= 1'b1;
            op_count_q <= '0;
        end else begin
            if (cmd_fire) begin
                op_q  <= cmd_op;
                imm_q <= cmd_imm;
            end
            if (state == EXEC) begin
                acc    <= acc_nxt;
                err_q  <= err_nxt;
                zero_q <= (acc_nxt == 4'h0);
            end
            if (rsp_fire && (op_count_q != {CNT_W{1'b1}})) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign alu_a      = imm_q[2:0];
    assign alu_b      = acc;
    assign alu_opcode = op_q[2:0];
    assign rsp_data   = acc;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural stand-in for the ALU.
// Inputs change and outputs are sampled 1ns after each rising edge.

module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_imm;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_err;
    logic [2:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_result;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_imm    (cmd_imm),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .op_count   (op_count)
    );

    // Stand-in 4-bit ALU: operand A zero-extended, SLT unsigned.
    always_comb begin
        case (alu_opcode)
            3'd0:    alu_result = {1'b0, alu_a} + alu_b;
            3'd1:    alu_result = {1'b0, alu_a} - alu_b;
            3'd2:    alu_result = {1'b0, alu_a} & alu_b;
            3'd3:    alu_result = {1'b0, alu_a} | alu_b;
            3'd4:    alu_result = ({1'b0, alu_a} < alu_b) ? 4'h1 : 4'h0;
            default: alu_result = 4'hF;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                           OP_SLT = 4'b0100, OP_LOAD = 4'b1000, OP_CLEAR = 4'b1001,
                           OP_READ = 4'b1010;

    // Reset-value vector: cmd_ready,rsp_valid,rsp_data,rsp_zero,rsp_err,alu_a,alu_b,alu_opcode,op_count
    localparam logic [26:0] RST_VEC = {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 3'h0, 4'h0, 3'h0, 8'h00};

    // Issues one command with rsp_ready high; returns the response and a latency flag.
    task automatic issue(input logic [3:0] op, input logic [3:0] imm,
                         output logic [3:0] d, output logic z, output logic e,
                         output logic lat_ok);
        int n;
        n = 0;
        lat_ok = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) lat_ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) lat_ok = 1'b0;
        @(posedge clk); #1;
        if (rsp_valid !== 1'b1) lat_ok = 1'b0;
        d = rsp_data;
        z = rsp_zero;
        e = rsp_err;
        @(posedge clk); #1;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) lat_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_imm   = 4'h0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_a, alu_b, alu_opcode, op_count} !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values got %h exp %h",
                     {cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_a, alu_b, alu_opcode, op_count}, RST_VEC);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        logic [3:0] d; logic z, e, ok;
        issue(OP_LOAD, 4'd4, d, z, e, ok);
        checks++;
        if ({d, z, e} !== {4'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load4 got data=%h zero=%b err=%b exp data=4 zero=0 err=0", d, z, e);
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL load_latency got %b exp 1", ok);
        end
        checks++;
        if (op_count !== 8'd1) begin
            errors++;
            $display("FAIL load_count got %0d exp 1", op_count);
        end
    endtask

    task automatic test_add();
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_imm   = 4'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if ({alu_a, alu_b, alu_opcode, cmd_ready} !== {3'd3, 4'd4, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL add_exec got a=%h b=%h opc=%h rdy=%b exp a=3 b=4 opc=0 rdy=0",
                     alu_a, alu_b, alu_opcode, cmd_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 4'd7, 1'b0}) begin
            errors++;
            $display("FAIL add_rsp got v=%b data=%h err=%b exp v=1 data=7 err=0", rsp_valid, rsp_data, rsp_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_slt();
        logic [3:0] d; logic z, e, ok;
        issue(OP_LOAD, 4'd5, d, z, e, ok);
        issue(OP_SUB, 4'd2, d, z, e, ok);
        checks++;
        if ({d, z, e} !== {4'hD, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub got data=%h zero=%b err=%b exp data=d zero=0 err=0", d, z, e);
        end
        issue(OP_SLT, 4'd1, d, z, e, ok);
        checks++;
        if ({d, z, e} !== {4'h1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL slt got data=%h zero=%b err=%b exp data=1 zero=0 err=0", d, z, e);
        end
        checks++;
        if (op_count !== 8'd5) begin
            errors++;
            $display("FAIL slt_count got %0d exp 5", op_count);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_AND;
        cmd_imm   = 4'd3;
        @(posedge clk); #1;
        cmd_op  = OP_LOAD;
        cmd_imm = 4'd7;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, cmd_ready, rsp_data, rsp_zero, rsp_err} !== {1'b1, 1'b0, 4'h1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b rdy=%b data=%h z=%b e=%b exp v=1 rdy=0 data=1 z=0 e=0",
                         i, rsp_valid, cmd_ready, rsp_data, rsp_zero, rsp_err);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, cmd_ready, rsp_data, op_count} !== {1'b0, 1'b1, 4'h1, 8'd6}) begin
            errors++;
            $display("FAIL bp_release got v=%b rdy=%b data=%h cnt=%0d exp v=0 rdy=1 data=1 cnt=6",
                     rsp_valid, cmd_ready, rsp_data, op_count);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, op_count} !== {1'b0, 8'd6}) begin
            errors++;
            $display("FAIL bp_single got v=%b cnt=%0d exp v=0 cnt=6", rsp_valid, op_count);
        end
    endtask

    task automatic test_illegal_clear();
        logic [3:0] d; logic z, e, ok;
        issue(4'b0110, 4'd7, d, z, e, ok);
        checks++;
        if ({d, e} !== {4'h1, 1'b1}) begin
            errors++;
            $display("FAIL illegal_0110 got data=%h err=%b exp data=1 err=1", d, e);
        end
        issue(4'b1111, 4'd2, d, z, e, ok);
        checks++;
        if ({d, e} !== {4'h1, 1'b1}) begin
            errors++;
            $display("FAIL illegal_1111 got data=%h err=%b exp data=1 err=1", d, e);
        end
        issue(OP_READ, 4'd0, d, z, e, ok);
        checks++;
        if ({d, z, e, op_count} !== {4'h1, 1'b0, 1'b0, 8'd9}) begin
            errors++;
            $display("FAIL read_after_illegal got data=%h z=%b err=%b cnt=%0d exp data=1 z=0 err=0 cnt=9",
                     d, z, e, op_count);
        end
        issue(OP_CLEAR, 4'd5, d, z, e, ok);
        checks++;
        if ({d, z, e} !== {4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL clear got data=%h zero=%b err=%b exp data=0 zero=1 err=0", d, z, e);
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] d; logic z, e, ok;
        logic seen;
        issue(OP_LOAD, 4'd6, d, z, e, ok);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_imm   = 4'd9;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_a, alu_b, alu_opcode, op_count} !== RST_VEC) begin
            errors++;
            $display("FAIL reset_in_exec got %h exp %h",
                     {cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_a, alu_b, alu_opcode, op_count}, RST_VEC);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if ({seen, rsp_data} !== {1'b0, 4'h0}) begin
            errors++;
            $display("FAIL exec_abort_no_rsp got seen=%b data=%h exp seen=0 data=0", seen, rsp_data);
        end

        issue(OP_LOAD, 4'd6, d, z, e, ok);
        cmd_valid = 1'b1;
        cmd_op    = OP_READ;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_a, alu_b, alu_opcode, op_count} !== RST_VEC) begin
            errors++;
            $display("FAIL reset_in_resp got %h exp %h",
                     {cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_a, alu_b, alu_opcode, op_count}, RST_VEC);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if ({seen, op_count} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL resp_abort_no_rsp got seen=%b cnt=%0d exp seen=0 cnt=0", seen, op_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d; logic z, e, ok;
        logic all_ok;
        all_ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(OP_READ, 4'd0, d, z, e, ok);
            if (!ok) all_ok = 1'b0;
            if (i == 254) begin
                checks++;
                if (op_count !== 8'd255) begin
                    errors++;
                    $display("FAIL count_at_255 got %0d exp 255", op_count);
                end
            end
        end
        checks++;
        if (op_count !== 8'd255) begin
            errors++;
            $display("FAIL count_saturate got %0d exp 255", op_count);
        end
        checks++;
        if (all_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_timing got %b exp 1", all_ok);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add();
        test_sub_slt();
        test_backpressure();
        test_illegal_clear();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
